sda_kernel_reg_master: RTL and testbench
========================================

# sda_kernel_reg_master

Initiator for the simple register interface (regReq/regAck/regWriteEn/regAddr/regWData/regRData). Terminates the host AXI4-Lite control port of an SDAccel kernel and turns each AXI read or write into exactly one register request to the ORed bank of register slaves behind it. It sits between the shell's s_axi_control port and the kernel's register slaves, including the kernel control register. A timeout converts a missing regAck into an AXI SLVERR so unmapped addresses cannot hang the host.

## Interface
- RegAddrWidth, 8: register address width; AXI address width is the same.
- TimeoutCycles, 64: cycles in a request state before abort; legal range 2..255.
- clk  in  1  system clock.
- srst  in  1  reset; one clock; synchronous, active-high.
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
- s_axi_awaddr  in  RegAddrWidth  write address.
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
- s_axi_wdata  in  32  write data; s_axi_wstrb  in  4  ignored, every write is full-word.
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake; s_axi_bresp  out  2.
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake; s_axi_araddr  in  RegAddrWidth.
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake; s_axi_rdata  out  32; s_axi_rresp  out  2.
- regReq  out  1  request, held until acked.
- regWriteEn  out  1  1 = write, 0 = read.
- regAddr  out  RegAddrWidth  register address.
- regWData  out  32  write data.
- regAck  in  1  single-cycle acknowledge from the ORed slaves.
- regRData  in  32  read data, valid only in the regAck cycle.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP. One transaction outstanding at a time.
- IDLE, write candidate: awvalid & wvalid both high. Read candidate: arvalid.
- Arbitration when both are candidates: the type not serviced last wins. After reset, write wins.
- Write accept: awready = wready = 1 combinationally in that IDLE cycle. Capture awaddr and wdata, then go to WR_REQ. A lone awvalid or lone wvalid is never accepted.
- Read accept: arready = 1 in that IDLE cycle. Capture araddr, then go to RD_REQ.
- *_REQ states:
  - regReq = 1; regWriteEn, regAddr and regWData are registered and stable for the whole state.
  - Counter clears on entry and increments each cycle.
- regAck sampled high in *_REQ:
  - Go to *_RESP; regReq is 0 from the next cycle.
  - Reads latch regRData into rdata; resp = OKAY (00).
- Timeout, counter = TimeoutCycles−1 with no ack:
  - Go to *_RESP with resp = SLVERR (10); rdata = 0.
  - Any regAck outside *_REQ is ignored. Slaves must ack within TimeoutCycles or never.
- *_RESP: bvalid or rvalid held with stable resp/data until the matching ready. Return to IDLE the cycle after the handshake.
- regWData and regAddr return to 0 when not in *_REQ, so the bus is quiet.

## Timing
- Reset values:
  - State IDLE; write has priority.
  - All ready, valid, regReq and regWriteEn outputs are 0.
  - regAddr, regWData, rdata, bresp and rresp are 0.
- srst mid-transaction aborts immediately: no response is issued and regReq drops the next cycle.
- Latency:
  - Accept at cycle t, regReq high at t+1.
  - Ack sampled at t+k, bvalid or rvalid high at t+k+1.
  - With the kernel control register slave (ack 2 cycles after request), k = 3. Accept to response is 4 cycles.
- Back-to-back: the earliest next accept is the IDLE cycle after a response handshake. regReq therefore has at least one low cycle between requests.
- bready/rready already high when valid rises: the handshake completes that cycle and valid drops the next.

## Test plan
- Write 0x1 to addr 0x00 with the control register attached -> awready/wready pulse, regReq high 3 cycles with regWriteEn=1 and regWData=0x1, bvalid 4 cycles after accept, bresp=00.
- Read addr 0x00 after a done -> rvalid with rdata bit1=1, rresp=00. A second read returns bit1=0.
- Read addr 0x40 with no responding slave, TimeoutCycles=16 -> regReq high exactly 16 cycles, then rvalid, rdata=0, rresp=10.
- awvalid, wvalid and arvalid held simultaneously from reset -> write serviced first, then the read. Repeat both -> order alternates W,R,W,R.
- awvalid alone for 10 cycles, then wvalid -> no awready until wvalid is present. Hold bready=0 for 5 cycles -> bvalid and bresp stay stable and no new accept occurs.
- srst asserted in RD_REQ -> next cycle regReq=0 and rvalid=0. A later read completes normally.

Source files
------------

// File: rtl/sda_kernel_reg_master.sv
// AXI4-Lite control-port terminator that turns each host read or write into a
// single request on the simple register bus, with a timeout that answers SLVERR.
module sda_kernel_reg_master #(
  parameter int unsigned RegAddrWidth  = 8,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [RegAddrWidth-1:0] s_axi_awaddr,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [RegAddrWidth-1:0] s_axi_araddr,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    regReq,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  input  logic                    regAck,
  input  logic [31:0]             regRData
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  localparam logic [7:0] LastCount = 8'(TimeoutCycles - 1);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic [2:0] state;
  logic       last_write;
  logic [7:0] count;
  logic       wr_accept;
  logic       rd_accept;
  logic       in_req;
  logic       expired;
  logic       wstrb_unused;

  // Every write is full-word, so the byte strobes carry no information.
  assign wstrb_unused = ^s_axi_wstrb;

  always_comb begin
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    if (state == IDLE && !srst) begin
      // Alternate between types when both are waiting; after reset write wins.
      wr_accept = s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !last_write);
      rd_accept = s_axi_arvalid && !wr_accept;
    end
  end

  assign in_req  = (state == WR_REQ) || (state == RD_REQ);
  assign expired = (count == LastCount);

  assign s_axi_awready = wr_accept;
  assign s_axi_wready  = wr_accept;
  assign s_axi_arready = rd_accept;
  assign s_axi_bvalid  = (state == WR_RESP);
  assign s_axi_rvalid  = (state == RD_RESP);
  assign regReq        = in_req;

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      last_write  <= 1'b0;
      count       <= '0;
      regWriteEn  <= 1'b0;
      regAddr     <= '0;
      regWData    <= '0;
      s_axi_rdata <= '0;
      s_axi_bresp <= RespOkay;
      s_axi_rresp <= RespOkay;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (wr_accept) begin
            state      <= WR_REQ;
            last_write <= 1'b1;
            regWriteEn <= 1'b1;
            regAddr    <= s_axi_awaddr;
            regWData   <= s_axi_wdata;
          end else if (rd_accept) begin
            state      <= RD_REQ;
            last_write <= 1'b0;
            regWriteEn <= 1'b0;
            regAddr    <= s_axi_araddr;
            regWData   <= '0;
          end
        end
        WR_REQ, RD_REQ: begin
          count <= count + 8'd1;
          // An ack arriving in the final counted cycle still wins over the timeout.
          if (regAck || expired) begin
            regWriteEn <= 1'b0;
            regAddr    <= '0;
            regWData   <= '0;
            if (state == WR_REQ) begin
              state       <= WR_RESP;
              s_axi_bresp <= regAck ? RespOkay : RespSlvErr;
            end else begin
              state       <= RD_RESP;
              s_axi_rresp <= regAck ? RespOkay : RespSlvErr;
              s_axi_rdata <= regAck ? regRData : '0;
            end
          end
        end
        WR_RESP: if (s_axi_bready) state <= IDLE;
        RD_RESP: if (s_axi_rready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sda_kernel_reg_master.sv
// Bench for sda_kernel_reg_master: AXI master and register-slave stimulus with a
// transaction-level reference model of acceptance order, request length and response.
module tb_sda_kernel_reg_master;

  localparam int unsigned AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          srst;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr, regAddr;
  logic [31:0]   wdata, rdata, regWData, regRData;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          regReq, regWriteEn, regAck;

  always #5 clk = ~clk;

  sda_kernel_reg_master #(.RegAddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk(clk), .srst(srst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .regReq(regReq), .regWriteEn(regWriteEn), .regAddr(regAddr), .regWData(regWData),
    .regAck(regAck), .regRData(regRData)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: register contents, current transaction and its expected shape.
  logic [31:0] mem [256];
  int          mphase;        // 0 idle, 1 request on the bus, 2 response offered
  bit          cur_w;
  logic [7:0]  cur_addr;
  logic [31:0] cur_data;
  int          req_cycles, exp_len;
  logic [1:0]  exp_resp;
  logic [31:0] exp_rdata;
  bit          last_write;
  int          slave_d, force_d, slave_cnt, rpct;
  bit          aw_hs, ar_hs;
  int          order_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic monitor();
    bit exp_w, exp_r, mapped, done;
    aw_hs = awvalid && awready;
    ar_hs = arvalid && arready;
    if (srst) begin
      mphase = 0;
      last_write = 0;
      return;
    end
    case (mphase)
      0: begin
        exp_w = awvalid && wvalid && (!arvalid || !last_write);
        exp_r = arvalid && !exp_w;
        chk("idle_awready", awready, exp_w);
        chk("idle_wready", wready, exp_w);
        chk("idle_arready", arready, exp_r);
        chk("idle_regReq", regReq, 0);
        chk("idle_regAddr", regAddr, 0);
        chk("idle_regWData", regWData, 0);
        chk("idle_bvalid", bvalid, 0);
        chk("idle_rvalid", rvalid, 0);
        if (exp_w || exp_r) begin
          cur_w      = exp_w;
          cur_addr   = exp_w ? awaddr : araddr;
          cur_data   = wdata;
          last_write = exp_w;
          order_q.push_back(int'(exp_w));
          slave_d    = (force_d != 0) ? force_d : int'($urandom_range(1, 8));
          mapped     = cur_addr < 8'h40;
          exp_len    = mapped ? slave_d : TO;
          exp_resp   = mapped ? 2'b00 : 2'b10;
          exp_rdata  = (!exp_w && mapped) ? mem[cur_addr] : 32'h0;
          if (exp_w && mapped) mem[cur_addr] = cur_data;
          req_cycles = 0;
          mphase     = 1;
        end
      end
      1: begin
        chk("req_regReq", regReq, 1);
        chk("req_regWriteEn", regWriteEn, cur_w);
        chk("req_regAddr", regAddr, cur_addr);
        if (cur_w) chk("req_regWData", regWData, cur_data);
        chk("req_bvalid", bvalid, 0);
        chk("req_rvalid", rvalid, 0);
        chk("req_awready", awready, 0);
        chk("req_arready", arready, 0);
        req_cycles++;
        if (req_cycles == exp_len) mphase = 2;
      end
      default: begin
        if (cur_w) begin
          chk("resp_bvalid", bvalid, 1);
          chk("resp_rvalid", rvalid, 0);
          chk("resp_bresp", bresp, exp_resp);
          done = bready;
        end else begin
          chk("resp_rvalid", rvalid, 1);
          chk("resp_bvalid", bvalid, 0);
          chk("resp_rresp", rresp, exp_resp);
          chk("resp_rdata", rdata, exp_rdata);
          done = rready;
        end
        chk("resp_regReq", regReq, 0);
        chk("resp_regAddr", regAddr, 0);
        chk("resp_regWData", regWData, 0);
        chk("resp_awready", awready, 0);
        chk("resp_arready", arready, 0);
        if (done) mphase = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (aw_hs) begin awvalid = 0; wvalid = 0; end
    if (ar_hs) arvalid = 0;
    bready = int'($urandom_range(0, 99)) < rpct;
    rready = int'($urandom_range(0, 99)) < rpct;
    // Register slave: plain memory below 0x40, silent above; stray acks when idle.
    if (srst) begin
      slave_cnt = 0;
      regAck = 0;
    end else if (regReq) begin
      slave_cnt++;
      if (regAddr < 8'h40 && slave_cnt == slave_d) begin
        regAck = 1;
        regRData = regWriteEn ? $urandom : mem[regAddr];
      end else begin
        regAck = 0;
        regRData = $urandom;
      end
    end else begin
      slave_cnt = 0;
      regAck = ($urandom_range(0, 7) == 0);
      regRData = $urandom;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((awvalid || wvalid || arvalid || mphase != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_done", {31'b0, (awvalid || wvalid || arvalid || mphase != 0)}, 0);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (mphase != ph && n < budget) begin
      tick();
      n++;
    end
    chk("wait_phase_reached", mphase, ph);
  endtask

  initial begin
    int kind;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    srst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 4'hF; regAck = 0; regRData = 0;
    rpct = 100; force_d = 0; slave_d = 1; slave_cnt = 0;
    mphase = 0; last_write = 0;
    repeat (3) tick();
    srst = 0;

    chk("rst_regReq", regReq, 0);
    chk("rst_regWriteEn", regWriteEn, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_regAddr", regAddr, 0);

    // Simultaneous write and read twice from reset, ack after three request cycles.
    force_d = 3;
    for (int r = 0; r < 2; r++) begin
      awaddr = 8'h00; wdata = 32'h1 + r; araddr = 8'h00;
      awvalid = 1; wvalid = 1; arvalid = 1;
      wait_idle(100);
    end
    chk("order_0", order_q[0], 1);
    chk("order_1", order_q[1], 0);
    chk("order_2", order_q[2], 1);
    chk("order_3", order_q[3], 0);
    force_d = 0;

    // Lone awvalid is not accepted; response held under bready low.
    awaddr = 8'h10; awvalid = 1;
    repeat (10) tick();
    wdata = $urandom; wvalid = 1; rpct = 0;
    wait_phase(2, 30);
    araddr = 8'h10; arvalid = 1;
    repeat (5) tick();
    rpct = 100;
    wait_idle(100);

    // Unmapped read times out after exactly TO request cycles.
    araddr = 8'h40; arvalid = 1;
    wait_idle(100);

    // Reset in the middle of a read request.
    force_d = 8;
    araddr = 8'h05; arvalid = 1;
    wait_phase(1, 20);
    srst = 1; awvalid = 0; wvalid = 0; arvalid = 0;
    tick();
    srst = 0;
    chk("abort_regReq", regReq, 0);
    chk("abort_rvalid", rvalid, 0);
    force_d = 0;
    araddr = 8'h05; arvalid = 1;
    wait_idle(100);

    // Randomized mix of writes, reads and simultaneous pairs.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0: rpct = 30;
        1: rpct = 70;
        default: rpct = 100;
      endcase
      awaddr = ($urandom_range(0, 3) == 0) ? 8'(8'h40 + $urandom_range(0, 8'hBF)) : 8'($urandom_range(0, 8'h3F));
      araddr = ($urandom_range(0, 3) == 0) ? 8'(8'h40 + $urandom_range(0, 8'hBF)) : 8'($urandom_range(0, 8'h3F));
      wdata  = $urandom;
      if (kind != 1) begin awvalid = 1; wvalid = 1; end
      if (kind != 0) arvalid = 1;
      wait_idle(300);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
